// File: rtl/rf_mp_sb_pkg.sv
// Shared types and helpers for the multi-port register file with busy-bit scoreboard.
// Contents:
//   RF_DW / RF_NREG / RF_AW    default data width, register count, address width
//   rf_addr_t / rf_data_t      default-sized address and data types
//   rf_port_hit()              write-port address match: hit flag + winning (highest) port index
package rf_mp_sb_pkg;

    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREG = 32;
    localparam int unsigned RF_AW   = $clog2(RF_NREG);

    // The hit helper works on fixed maximum-sized vectors so it can serve any
    // instance; callers zero-extend addresses and leave unused port enables low.
    localparam int unsigned RF_MAX_WR   = 8;
    localparam int unsigned RF_MAX_AW   = 16;
    localparam int unsigned RF_WR_IDX_W = $clog2(RF_MAX_WR);

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef logic [RF_MAX_AW-1:0]                rf_wide_addr_t;
    typedef logic [RF_MAX_WR-1:0]                rf_wr_en_vec_t;
    typedef logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] rf_wr_addr_vec_t;

    typedef struct packed {
        logic                   hit;
        logic [RF_WR_IDX_W-1:0] idx;
    } rf_hit_t;

    // Later iterations overwrite earlier ones, so the highest matching port wins.
    function automatic rf_hit_t rf_port_hit(input rf_wide_addr_t   addr,
                                            input rf_wr_en_vec_t   wr_en,
                                            input rf_wr_addr_vec_t wr_addr);
        rf_hit_t res;
        res = '0;
        for (int unsigned i = 0; i < RF_MAX_WR; i++) begin
            if (wr_en[i] && (wr_addr[i] == addr)) begin
                res.hit = 1'b1;
                res.idx = RF_WR_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_mp_sb_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
// Signals:
//   wr_en/wr_addr/wr_data   NWR writeback ports, port i at [i*W +: W]
//   rd_addr/rd_data/rd_busy NRD read ports, data and busy are combinational
//   iss_en/iss_addr         issue strobe marking a destination pending
//   sb_flush                clears every busy bit at the next edge
//   busy_vec                registered busy bits
interface rf_mp_sb_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              sb_flush;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, sb_flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, sb_flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/rf_mp_sb_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register.
// Priority per register: flush clears > issue sets > writeback clears > hold.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   iss_en, iss_addr  issue strobe and destination
//   sb_flush          synchronous clear of all bits
//   wr_en, wr_addr    qualified writeback enables and addresses
//   busy_vec          registered busy flags
module rf_mp_sb_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic                    sb_flush,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    output logic [NREG-1:0]         busy_vec
);

    localparam bit ZeroReg = (ZERO_REG != 0);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (iss_en) begin
            set_v[iss_addr] = 1'b1;
        end
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                clr_v[wr_addr[i]] = 1'b1;
            end
        end
        if (ZeroReg) begin
            set_v[0] = 1'b0;
        end
        // Set dominates clear so a same-cycle reissue keeps the register pending.
        if (sb_flush) begin
            busy_d = '0;
        end else begin
            busy_d = set_v | (busy_q & ~clr_v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port integer register file with write-through bypass and busy-bit scoreboard.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset; clears data and busy bits
//   bus   rf_mp_sb_if slave: NWR write ports, NRD combinational read ports with
//         bypass and busy, issue/flush scoreboard controls, busy_vec
// NWR must not exceed RF_MAX_WR and $clog2(NREG) must not exceed RF_MAX_AW.
module rf_mp_sb
    import rf_mp_sb_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic       clk,
    input  logic       rst,
    rf_mp_sb_if.slave  bus
);

    localparam int unsigned AW      = $clog2(NREG);
    localparam bit          ZeroReg = (ZERO_REG != 0);

    logic [NWR-1:0][AW-1:0] wr_addr_arr;
    logic [NWR-1:0][DW-1:0] wr_data_arr;
    logic [NRD-1:0][AW-1:0] rd_addr_arr;
    logic [NWR-1:0]         wr_act;
    logic [NREG-1:0][DW-1:0] regs_q;
    logic [NREG-1:0]        busy_vec;

    rf_wr_en_vec_t   wr_act_ext;
    rf_wr_addr_vec_t wr_addr_ext;

    assign wr_addr_arr = bus.wr_addr;
    assign wr_data_arr = bus.wr_data;
    assign rd_addr_arr = bus.rd_addr;

    // Writes to x0 are dropped here so neither the array, the bypass nor the
    // scoreboard ever sees them.
    always_comb begin
        wr_act      = '0;
        wr_act_ext  = '0;
        wr_addr_ext = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            wr_act[i]      = bus.wr_en[i] && !(ZeroReg && (wr_addr_arr[i] == '0));
            wr_act_ext[i]  = wr_act[i];
            wr_addr_ext[i] = rf_wide_addr_t'(wr_addr_arr[i]);
        end
    end

    // Non-blocking updates in port order: the highest port index lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_act[i]) begin
                    regs_q[wr_addr_arr[i]] <= wr_data_arr[i];
                end
            end
        end
    end

    rf_mp_sb_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .sb_flush (bus.sb_flush),
        .wr_en    (wr_act),
        .wr_addr  (wr_addr_arr),
        .busy_vec (busy_vec)
    );

    assign bus.busy_vec = busy_vec;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        rf_hit_t       hit;
        logic [DW-1:0] byp_data;
        logic [DW-1:0] rd_val;
        logic          rd_is_zero;
        logic          rd_busy_v;

        always_comb begin
            hit      = rf_port_hit(rf_wide_addr_t'(rd_addr_arr[j]), wr_act_ext, wr_addr_ext);
            byp_data = '0;
            for (int unsigned i = 0; i < NWR; i++) begin
                if (hit.idx == RF_WR_IDX_W'(i)) begin
                    byp_data = wr_data_arr[i];
                end
            end
            rd_is_zero = ZeroReg && (rd_addr_arr[j] == '0);
            if (rd_is_zero) begin
                rd_val = '0;
            end else if (hit.hit) begin
                rd_val = byp_data;
            end else begin
                rd_val = regs_q[rd_addr_arr[j]];
            end
            // Looks only at registered busy bits: a same-cycle issue never stalls its own decode.
            rd_busy_v = busy_vec[rd_addr_arr[j]] && !hit.hit && !bus.sb_flush && !rd_is_zero;
        end

        assign bus.rd_data[j*DW +: DW] = rd_val;
        assign bus.rd_busy[j]          = rd_busy_v;
    end

endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed bench for rf_mp_sb (NWR=2, NRD=2, ZERO_REG=1). Expected values are queued
// when stimulus is driven and popped when the DUT output is sampled.
module tb_rf_mp_sb;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_mp_sb_if #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    rf_mp_sb #(
        .DW       (DW),
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        exp_q.push_back(item);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL empty_queue: observed %h required <nothing queued>", obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic clear_in();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.sb_flush = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW] = a;
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd0();
        return bus.rd_data[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return bus.rd_data[63:32];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        #12;
        rst = 1'b0;

        // Reset state
        rd(0, 5'd5);
        expect_val("reset_rd_x5", 32'h0);
        expect_val("reset_busy_vec", 32'h0);
        #1;
        check(rd0());
        check(bus.busy_vec);
        tick();

        // Write x5, issue x6, then asynchronous reset mid-cycle
        wr(0, 5'd5, 32'h0000_DEAD);
        iss(5'd6);
        rd(0, 5'd5);
        expect_val("wr_x5_bypass", 32'h0000_DEAD);
        #1;
        check(rd0());
        tick();
        clear_in();
        rd(0, 5'd5);
        expect_val("wr_x5_stored", 32'h0000_DEAD);
        expect_val("busy_x6_set", 32'h0000_0040);
        #1;
        check(rd0());
        check(bus.busy_vec);
        #1;
        rst = 1'b1;
        expect_val("async_rst_rd_x5", 32'h0);
        expect_val("async_rst_busy_vec", 32'h0);
        #1;
        check(rd0());
        check(bus.busy_vec);
        rst = 1'b0;
        tick();

        // x0 hardwired: write and issue ignored
        clear_in();
        wr(0, 5'd0, 32'hFFFF_FFFF);
        iss(5'd0);
        rd(0, 5'd0);
        expect_val("x0_rd_during_wr", 32'h0);
        expect_val("x0_rd_busy", 32'h0);
        #1;
        check(rd0());
        check({31'b0, bus.rd_busy[0]});
        tick();
        clear_in();
        rd(0, 5'd0);
        expect_val("x0_busy_vec0", 32'h0);
        expect_val("x0_rd_after", 32'h0);
        #1;
        check({31'b0, bus.busy_vec[0]});
        check(rd0());
        tick();

        // Two ports to x7: port 1 wins, bypass and stored
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        rd(0, 5'd7);
        expect_val("prio_bypass_x7", 32'h22);
        #1;
        check(rd0());
        tick();
        clear_in();
        rd(0, 5'd7);
        expect_val("prio_stored_x7", 32'h22);
        expect_val("prio_busy_vec", 32'h0);
        #1;
        check(rd0());
        check(bus.busy_vec);
        tick();

        // Issue/writeback overlap on x3
        iss(5'd3);
        tick();
        clear_in();
        iss(5'd3);
        wr(0, 5'd3, 32'h44);
        rd(0, 5'd3);
        expect_val("ovl_busy_before", 32'h0000_0008);
        expect_val("ovl_rd_bypass", 32'h44);
        expect_val("ovl_rd_busy_written", 32'h0);
        #1;
        check(bus.busy_vec);
        check(rd0());
        check({31'b0, bus.rd_busy[0]});
        tick();
        clear_in();
        rd(0, 5'd3);
        expect_val("ovl_busy_after", 32'h0000_0008);
        expect_val("ovl_rd_stored", 32'h44);
        expect_val("ovl_rd_busy_after", 32'h1);
        #1;
        check(bus.busy_vec);
        check(rd0());
        check({31'b0, bus.rd_busy[0]});
        tick();

        // RAW on x9: issue, wait, writeback
        iss(5'd9);
        rd(1, 5'd9);
        expect_val("raw_no_self_stall", 32'h0);
        #1;
        check({31'b0, bus.rd_busy[1]});
        tick();
        clear_in();
        rd(1, 5'd9);
        expect_val("raw_busy_pending", 32'h1);
        #1;
        check({31'b0, bus.rd_busy[1]});
        tick();
        wr(1, 5'd9, 32'h99);
        expect_val("raw_busy_wb_cycle", 32'h0);
        expect_val("raw_bypass_x9", 32'h99);
        #1;
        check({31'b0, bus.rd_busy[1]});
        check(rd1());
        tick();
        clear_in();
        rd(1, 5'd9);
        expect_val("raw_busy_vec_after", 32'h0000_0008);
        expect_val("raw_stored_x9", 32'h99);
        #1;
        check(bus.busy_vec);
        check(rd1());
        tick();

        // Flush with concurrent issue of x4
        iss(5'd1);
        tick();
        iss(5'd2);
        tick();
        iss(5'd31);
        tick();
        clear_in();
        rd(0, 5'd1);
        expect_val("flush_busy_before", 32'h8000_000E);
        expect_val("flush_rd_busy_x1_pre", 32'h1);
        #1;
        check(bus.busy_vec);
        check({31'b0, bus.rd_busy[0]});
        bus.sb_flush = 1'b1;
        iss(5'd4);
        expect_val("flush_rd_busy_x1", 32'h0);
        #1;
        check({31'b0, bus.rd_busy[0]});
        tick();
        clear_in();
        expect_val("flush_busy_after", 32'h0);
        #1;
        check(bus.busy_vec);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
